// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the immediate encoder.
//
// The sel encoding matches the decode-side immediate generator, so a
// (template, imm, sel) triple that the encoder packs can be decoded back
// with the same sel value.
//
// Contents:
//   imm_sel_e  - 3-bit format select (I, S, B, J, U); 101..111 are illegal
//   ERR_CNT_W  - width of the saturating error counter (IMM_RANGE_CHECK_EN)
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_sel_e;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/imm_field_pack.sv
// Combinational immediate packer: writes the format's immediate fields of
// imm into the template instruction; every other template bit is kept.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   - err also flags immediates the format cannot represent
//   undefined - err flags only an illegal sel
//
// Ports:
//   template  in  32  instruction whose non-immediate bits are preserved
//   imm       in  32  immediate value (byte offset for B and J)
//   sel       in  3   format select (imm_sel_e); 101..111 illegal
//   instr     out 32  patched instruction (template itself for illegal sel)
//   err       out 1   illegal sel, or unrepresentable imm with the macro
module imm_field_pack
  import riscv_imm_pkg::*;
(
  input  logic [31:0] template,
  input  logic [31:0] imm,
  input  logic [2:0]  sel,
  output logic [31:0] instr,
  output logic        err
);

  logic sel_err;
  logic range_err;

  // Immediate bits not covered by a format are simply not copied.
  always_comb begin
    instr   = template;
    sel_err = 1'b0;
    case (imm_sel_e'(sel))
      IMM_I: begin
        instr[31:20] = imm[11:0];
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
      end
      default: begin
        sel_err = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits a signed field when every bit above the field's sign
  // bit equals that sign bit; B and J offsets must also be even.
  logic is_ok;
  logic b_ok;
  logic j_ok;
  logic u_ok;

  assign is_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok  = ~(|imm[11:0]);

  always_comb begin
    range_err = 1'b0;
    case (imm_sel_e'(sel))
      IMM_I:   range_err = ~is_ok;
      IMM_S:   range_err = ~is_ok;
      IMM_B:   range_err = ~b_ok;
      IMM_J:   range_err = ~j_ok;
      IMM_U:   range_err = ~u_ok;
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err = sel_err | range_err;

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: patches an immediate into a template instruction
// (inverse of the decode-stage immediate generator). Two-stage pipeline:
// stage 1 registers the request, packing happens combinationally between
// stage 1 and the output register (stage 2).
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   - out_err also flags unrepresentable immediates and the
//               err_count port / register exist
//   undefined - out_err flags only an illegal sel; no err_count
//
// Ports:
//   clk        in  1   clock
//   rst_n      in  1   asynchronous active-low reset
//   in_valid   in  1   input beat present
//   in_ready   out 1   input beat accepted this cycle
//   in_instr   in  32  template instruction
//   in_imm     in  32  immediate value
//   in_sel     in  3   format select (imm_sel_e)
//   out_valid  out 1   output beat present
//   out_ready  in  1   downstream accepts the output beat
//   out_instr  out 32  patched instruction
//   out_err    out 1   error flag for this beat
//   err_count  out 8   saturating count of errored output transfers (macro)
//
// Handshake: a beat moves across an interface at a rising clk edge where
// valid and ready are both 1. A producer holds valid and its payload until
// that edge; valid never depends on ready. in_ready depends only on
// pipeline state and out_ready, never on in_valid.
module imm_encoder
  import riscv_imm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_imm,
  input  logic [2:0]           in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic [31:0] s1_imm;
  logic [2:0]  s1_sel;

  logic        s2_ready;
  logic [31:0] pack_instr;
  logic        pack_err;

  // Stage 2 can take a beat when empty or draining this cycle; stage 1 can
  // take one when empty or when it moves into stage 2 at the same edge,
  // which is what keeps full throughput without a bubble.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_imm   <= '0;
      s1_sel   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_instr <= in_instr;
        s1_imm   <= in_imm;
        s1_sel   <= in_sel;
      end
    end
  end

  imm_field_pack u_pack (
    .template (s1_instr),
    .imm      (s1_imm),
    .sel      (s1_sel),
    .instr    (pack_instr),
    .err      (pack_err)
  );

  // Payload only loads alongside a new beat, so it stays stable while the
  // downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= pack_instr;
        out_err   <= pack_err;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  // Counts errored beats as they leave, so a stalled beat counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder. Builds with or without
// IMM_RANGE_CHECK_EN; error-count checks exist only with the macro.
module tb_imm_encoder;
  import riscv_imm_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_imm;
  logic [2:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
`ifdef IMM_RANGE_CHECK_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_imm    (in_imm),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .err_count (err_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];      // {err, instr} in acceptance order
  logic [31:0] imm_q[$];
  logic [2:0]  sel_q[$];
  int          exp_err_cnt = 0;
  bit          rand_bp = 1'b0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Which immediate bit lands in instruction bit p for each format (-1: keep).
  function automatic int src_bit(input logic [2:0] sel, input int p);
    case (sel)
      3'd0: return (p >= 20) ? p - 20 : -1;
      3'd1: return (p >= 25) ? p - 20 : ((p >= 7 && p <= 11) ? p - 7 : -1);
      3'd2: begin
        if (p == 31) return 12;
        if (p >= 25 && p <= 30) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
        return -1;
      end
      3'd3: begin
        if (p == 31) return 20;
        if (p >= 21 && p <= 30) return p - 20;
        if (p == 20) return 11;
        if (p >= 12 && p <= 19) return p;
        return -1;
      end
      3'd4: return (p >= 12) ? p : -1;
      default: return -1;
    endcase
  endfunction

  // Whether the format can hold imm exactly, from its numeric range.
  function automatic bit repr(input logic [31:0] imm, input logic [2:0] sel);
    int v;
    v = $signed(imm);
    case (sel)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      3'd3:       return (v >= -(1 << 20)) && (v < (1 << 20)) && (v % 2 == 0);
      3'd4:       return (imm % 4096) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [32:0] ref_pack(input logic [31:0] t, input logic [31:0] imm,
                                           input logic [2:0] sel);
    logic [31:0] r;
    logic        e;
    int          s;
    r = t;
    for (int p = 0; p < 32; p++) begin
      s = src_bit(sel, p);
      if (s >= 0) r[p] = imm[s];
    end
    e = (sel > 3'd4);
`ifdef IMM_RANGE_CHECK_EN
    if (!e) e = !repr(imm, sel);
`endif
    return {e, r};
  endfunction

  // Decode-side immediate generator, used for the round-trip property.
  function automatic logic [31:0] decode(input logic [31:0] x, input logic [2:0] sel);
    case (sel)
      3'd0:    return {{20{x[31]}}, x[31:20]};
      3'd1:    return {{20{x[31]}}, x[31:25], x[11:7]};
      3'd2:    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd3:    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return {x[31:12], 12'b0};
    endcase
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] im;
    logic [2:0]  sl;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("stale_or_extra_beat", {32'b0, out_valid}, 33'd0);
      end else begin
        e  = exp_q.pop_front();
        im = imm_q.pop_front();
        sl = sel_q.pop_front();
        check("beat", {out_err, out_instr}, e);
        if (e[32]) exp_err_cnt++;
        if (sl <= 3'd4 && repr(im, sl))
          check("round_trip", {1'b0, decode(out_instr, sl)}, {1'b0, im});
      end
    end
  end

  always @(negedge clk) begin
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [31:0] imm, input logic [2:0] sel, input logic [32:0] e);
    exp_q.push_back(e);
    imm_q.push_back(imm);
    sel_q.push_back(sel);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] imm,
                      input logic [2:0] sel, input logic [32:0] e);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_imm   = imm;
    in_sel   = sel;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("accept_timeout", {32'b0, in_ready}, 33'd1);
    else push_exp(imm, sel, e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    rand_bp = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    #2;
    check("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  function automatic int min255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] t, im;
    logic [2:0]  sl;
    logic [32:0] ea;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_imm    = '0;
    in_sel    = '0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", {32'b0, out_valid}, 33'd0);
    check("reset_out_instr", {out_err, out_instr}, 33'd0);
    check("reset_in_ready", {32'b0, in_ready}, 33'd1);
`ifdef IMM_RANGE_CHECK_EN
    check("reset_err_count", {25'b0, err_count}, 33'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: not visible after the accepting edge, visible after the next.
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_imm = 32'hFFFF_FFFF; in_sel = 3'd0;
    #1;
    check("ready_after_reset", {32'b0, in_ready}, 33'd1);
    push_exp(32'hFFFF_FFFF, 3'd0, {1'b0, 32'hFFF0_0013});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_not_yet", {32'b0, out_valid}, 33'd0);
    @(posedge clk);
    #1;
    check("lat_valid", {32'b0, out_valid}, 33'd1);
    check("lat_I_data", {out_err, out_instr}, {1'b0, 32'hFFF0_0013});
    drain();

    send(32'h0000_2023, 32'h0000_0010, 3'd1, {1'b0, 32'h0000_2823});
    send(32'h0000_0063, 32'hFFFF_FFFC, 3'd2, {1'b0, 32'hFE00_0EE3});
    send(32'h0000_006F, 32'h0000_0800, 3'd3, {1'b0, 32'h0010_006F});
    send(32'h0000_0037, 32'h1234_5000, 3'd4, {1'b0, 32'h1234_5037});
`ifdef IMM_RANGE_CHECK_EN
    send(32'h0000_0013, 32'h0000_0800, 3'd0, {1'b1, 32'h8000_0013});
    drain();
    check("err_count_one", {25'b0, err_count}, 33'd1);
`else
    send(32'h0000_0013, 32'h0000_0800, 3'd0, {1'b0, 32'h8000_0013});
`endif
    send(32'hDEAD_BEEF, 32'h1234_5678, 3'd7, {1'b1, 32'hDEAD_BEEF});
    drain();

    // Back-pressure: out_ready low for 5 cycles while offering 3 beats.
    out_ready = 1'b0;
    t = 32'h0000_0013; im = 32'h0000_0123;
    ea = ref_pack(t, im, 3'd0);
    send(t, im, 3'd0, ea);
    send(32'h0000_2023, 32'hFFFF_FFF0, 3'd1, ref_pack(32'h0000_2023, 32'hFFFF_FFF0, 3'd1));
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_0037; in_imm = 32'hABCDE000; in_sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready_low", {32'b0, in_ready}, 33'd0);
      check("bp_out_hold", {out_err, out_instr}, ea);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {32'b0, in_ready}, 33'd1);
    push_exp(32'hABCDE000, 3'd4, ref_pack(32'h0000_0037, 32'hABCDE000, 3'd4));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Randomised traffic with random back-pressure and idle gaps.
    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      t  = $urandom;
      sl = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      case ($urandom_range(0, 3))
        0: im = $urandom;
        1: im = 32'($signed($urandom_range(0, 4095)) - 2048);
        2: im = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
        default: im = $urandom & 32'hFFFF_F000;
      endcase
      send(t, im, sl, ref_pack(t, im, sl));
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    drain();
`ifdef IMM_RANGE_CHECK_EN
    check("err_count_random", {25'b0, err_count}, 33'(min255(exp_err_cnt)));
`endif

    // Reset with two beats in flight: both must vanish.
    send(32'h0000_0013, 32'h0000_0001, 3'd0, ref_pack(32'h0000_0013, 32'h0000_0001, 3'd0));
    send(32'h0000_0013, 32'h0000_0002, 3'd0, ref_pack(32'h0000_0013, 32'h0000_0002, 3'd0));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {32'b0, out_valid}, 33'd0);
    check("midrst_in_ready", {32'b0, in_ready}, 33'd1);
    exp_q.delete();
    imm_q.delete();
    sel_q.delete();
    exp_err_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", {32'b0, in_ready}, 33'd1);
    repeat (6) @(negedge clk);
    #2;
    check("postrst_no_stale", {32'b0, out_valid}, 33'd0);
`ifdef IMM_RANGE_CHECK_EN
    check("postrst_err_count", {25'b0, err_count}, 33'd0);
`endif

    // Many errored beats: the counter must saturate.
    for (int n = 0; n < 300; n++) begin
      t = $urandom;
      send(t, $urandom, 3'd5 + 3'($urandom_range(0, 2)), {1'b1, t});
    end
    drain();
    check("err_beats_seen", 33'(exp_err_cnt), 33'd300);
`ifdef IMM_RANGE_CHECK_EN
    check("err_count_sat", {25'b0, err_count}, 33'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
